// File: rtl/uart_cmd_responder_pkg.sv
// rtl/uart_cmd_responder_pkg.sv - frame constants, state encoding and status rule for the UART command responder
package uart_cmd_responder_pkg;

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_ECHO  = 8'h03;

  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_BAD_CHK  = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD  = 8'h02;
  localparam logic [7:0] STATUS_BAD_ADDR = 8'h03;

  localparam int REQ_LEN = 5;
  localparam int RSP_LEN = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CHK,
    ST_EXEC,
    ST_TX_ISSUE,
    ST_TX_GUARD,
    ST_TX_WAIT
  } state_t;

  // Checksum beats command, command beats address; echo never looks at the address.
  function automatic logic [7:0] calc_status(input logic [7:0] cmd, input logic [7:0] addr,
                                             input logic [7:0] data, input logic [7:0] chk,
                                             input int num_regs);
    if (chk != (cmd ^ addr ^ data))
      return STATUS_BAD_CHK;
    if (cmd != CMD_WRITE && cmd != CMD_READ && cmd != CMD_ECHO)
      return STATUS_BAD_CMD;
    if (cmd != CMD_ECHO && int'(addr) >= num_regs)
      return STATUS_BAD_ADDR;
    return STATUS_OK;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// rtl/uart_frame_timeout.sv - loadable inter-byte down-counter with clear and expire strobe
module uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)
      r_cnt <= LOAD_VAL;
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  // A clear in the expiring cycle wins, so a byte arriving right at the limit keeps the frame.
  assign o_expire = i_en && !i_clr && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - parses 5-byte request frames, runs the register op, returns a 4-byte response
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          i_system_clk,
  input  logic          i_reset,
  input  logic          i_rx_complete,
  input  logic [7:0]    i_rx_data,
  input  logic [1:0]    i_rx_error_bit,
  input  logic          i_tx_busy,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_wr_en,
  output logic          o_reg_wr_en,
  output logic [AW-1:0] o_reg_addr,
  output logic [7:0]    o_reg_wdata,
  input  logic [7:0]    i_reg_rdata,
  output logic          o_pkt_ok,
  output logic          o_pkt_err,
  output logic          o_timeout,
  output logic          o_busy
);

  state_t        r_state;
  logic [7:0]    r_cmd;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic [7:0]    r_status;
  logic [7:0]    r_rdata;
  logic [1:0]    r_idx;
  logic [7:0]    r_tx_data;
  logic          r_tx_wr_en;
  logic          r_reg_wr_en;
  logic [AW-1:0] r_reg_addr;
  logic [7:0]    r_reg_wdata;
  logic          r_pkt_ok;
  logic          r_pkt_err;
  logic          r_timeout;

  logic       w_in_get;
  logic       w_byte_ok;
  logic       w_byte_bad;
  logic       w_expire;
  logic [7:0] w_status;
  logic [7:0] w_rsp_byte;

  assign w_in_get   = (r_state == ST_GET_CMD) || (r_state == ST_GET_ADDR) ||
                      (r_state == ST_GET_DATA) || (r_state == ST_GET_CHK);
  assign w_byte_ok  = i_rx_complete && (i_rx_error_bit == 2'b00);
  assign w_byte_bad = i_rx_complete && (i_rx_error_bit != 2'b00);
  assign w_status   = calc_status(r_cmd, r_addr, r_data, i_rx_data, NUM_REGS);

  always_comb begin
    w_rsp_byte = SOF_RSP;
    case (r_idx)
      2'd1:    w_rsp_byte = r_status;
      2'd2:    w_rsp_byte = r_rdata;
      2'd3:    w_rsp_byte = r_status ^ r_rdata;
      default: w_rsp_byte = SOF_RSP;
    endcase
  end

  uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_system_clk),
    .i_reset  (i_reset),
    .i_clr    (i_rx_complete || (r_state == ST_IDLE)),
    .i_en     (w_in_get),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_system_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_status    <= '0;
      r_rdata     <= '0;
      r_idx       <= '0;
      r_tx_data   <= '0;
      r_tx_wr_en  <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_tx_wr_en  <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_byte_ok && i_rx_data == SOF_REQ)
            r_state <= ST_GET_CMD;
        end
        ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
          if (w_byte_bad) begin
            r_pkt_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_byte_ok) begin
            case (r_state)
              ST_GET_CMD: begin
                r_cmd   <= i_rx_data;
                r_state <= ST_GET_ADDR;
              end
              ST_GET_ADDR: begin
                r_addr     <= i_rx_data;
                r_reg_addr <= i_rx_data[AW-1:0];
                r_state    <= ST_GET_DATA;
              end
              ST_GET_DATA: begin
                r_data  <= i_rx_data;
                r_state <= ST_GET_CHK;
              end
              default: begin
                // Status is decided on the CHK byte so the write strobe and the
                // ok/err pulse land in the EXEC cycle itself.
                r_status <= w_status;
                if (w_status == STATUS_OK) begin
                  r_pkt_ok <= 1'b1;
                  if (r_cmd == CMD_WRITE) begin
                    r_reg_wr_en <= 1'b1;
                    r_reg_wdata <= r_data;
                  end
                end else begin
                  r_pkt_err <= 1'b1;
                end
                r_state <= ST_EXEC;
              end
            endcase
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (r_status != STATUS_OK)
            r_rdata <= 8'h00;
          else if (r_cmd == CMD_READ)
            r_rdata <= i_reg_rdata;
          else if (r_cmd == CMD_ECHO)
            r_rdata <= r_data;
          else
            r_rdata <= 8'h00;
          r_idx   <= 2'd0;
          r_state <= ST_TX_ISSUE;
        end
        ST_TX_ISSUE: begin
          if (!i_tx_busy) begin
            r_tx_data  <= w_rsp_byte;
            r_tx_wr_en <= 1'b1;
            r_state    <= ST_TX_GUARD;
          end
        end
        ST_TX_GUARD: begin
          r_state <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (!i_tx_busy) begin
            if (r_idx == 2'(RSP_LEN - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_TX_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_wr_en  = r_tx_wr_en;
  assign o_reg_wr_en = r_reg_wr_en;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_pkt_ok    = r_pkt_ok;
  assign o_pkt_err   = r_pkt_err;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - randomized frame bench for uart_cmd_responder against a frame-level model
module tb_uart_cmd_responder;
  import uart_cmd_responder_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int TO       = 50;
  localparam int AW       = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_complete;
  logic [7:0]    rx_data;
  logic [1:0]    rx_err;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic          reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata;
  logic          pkt_ok;
  logic          pkt_err;
  logic          timeout;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] bus_regs   [NUM_REGS];
  logic [7:0] init_vals  [NUM_REGS];
  logic [7:0] model_regs [NUM_REGS];
  logic       load_regs;

  int busy_hold;
  int busy_cnt;
  logic busy_prev;

  logic [7:0]    tx_q [$];
  logic [AW+7:0] wr_q [$];
  int n_ok, n_err, n_to;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .NUM_REGS(NUM_REGS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_system_clk   (clk),
    .i_reset        (reset),
    .i_rx_complete  (rx_complete),
    .i_rx_data      (rx_data),
    .i_rx_error_bit (rx_err),
    .i_tx_busy      (tx_busy),
    .o_tx_data      (tx_data),
    .o_tx_wr_en     (tx_wr_en),
    .o_reg_wr_en    (reg_wr_en),
    .o_reg_addr     (reg_addr),
    .o_reg_wdata    (reg_wdata),
    .i_reg_rdata    (reg_rdata),
    .o_pkt_ok       (pkt_ok),
    .o_pkt_err      (pkt_err),
    .o_timeout      (timeout),
    .o_busy         (busy)
  );

  assign reg_rdata = bus_regs[reg_addr];
  assign tx_busy   = (busy_cnt != 0);

  always @(posedge clk) begin
    if (load_regs) begin
      for (int i = 0; i < NUM_REGS; i++) bus_regs[i] <= init_vals[i];
    end else if (reg_wr_en) begin
      bus_regs[reg_addr] <= reg_wdata;
    end
  end

  // Transmitter stand-in: goes busy the cycle after each write strobe.
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (tx_wr_en) busy_cnt <= busy_hold;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_wr_en) begin
      tx_q.push_back(tx_data);
      check_eq("tx_issued_while_busy", {31'b0, busy_prev}, 32'd0);
    end
    if (reg_wr_en) wr_q.push_back({reg_addr, reg_wdata});
    n_ok      <= n_ok + int'(pkt_ok);
    n_err     <= n_err + int'(pkt_err);
    n_to      <= n_to + int'(timeout);
    busy_prev <= tx_busy;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
    rx_complete = 1'b1;
    rx_data     = b;
    rx_err      = e;
    align();
    rx_complete = 1'b0;
    rx_data     = 8'h00;
    rx_err      = 2'b00;
  endtask

  task automatic gap(input int g);
    repeat (g) align();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("resp_done", {31'b0, busy}, 32'd0);
  endtask

  function automatic void model_req(input logic [7:0] cmd, input logic [7:0] addr,
                                    input logic [7:0] data, input logic [7:0] chk,
                                    output logic [7:0] st, output logic [7:0] rd, output bit wr);
    rd = 8'h00;
    wr = 1'b0;
    if (chk !== (cmd ^ addr ^ data)) st = STATUS_BAD_CHK;
    else if (cmd < 8'h01 || cmd > 8'h03) st = STATUS_BAD_CMD;
    else if (cmd != CMD_ECHO && addr >= 8'(NUM_REGS)) st = STATUS_BAD_ADDR;
    else st = STATUS_OK;
    if (st == STATUS_OK) begin
      if (cmd == CMD_WRITE) wr = 1'b1;
      else if (cmd == CMD_READ) rd = model_regs[addr[AW-1:0]];
      else rd = data;
    end
  endfunction

  // g < 0 picks random inter-byte gaps; inject sends a stray frame while the response is going out.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] chk, input int hold, input int g, input bit inject);
    logic [7:0] st, rd, req [REQ_LEN], rsp [RSP_LEN];
    bit         wr;
    int         tx0, ok0, err0, wr0;
    model_req(cmd, addr, data, chk, st, rd, wr);
    req = '{SOF_REQ, cmd, addr, data, chk};
    rsp = '{SOF_RSP, st, rd, st ^ rd};
    tx0 = tx_q.size(); ok0 = n_ok; err0 = n_err; wr0 = wr_q.size();
    busy_hold = hold;
    align();
    for (int i = 0; i < REQ_LEN; i++) begin
      gap((g < 0) ? $urandom_range(0, 3) : g);
      send_byte(req[i], 2'b00);
    end
    @(negedge clk);
    check_eq("wr_latency", {31'b0, reg_wr_en}, {31'b0, wr});
    if (inject) begin
      align();
      for (int i = 0; i < REQ_LEN; i++) begin
        gap(1);
        send_byte(req[i] ^ ((i == 1) ? 8'h03 : 8'h00), 2'b00);
      end
    end
    wait_idle(600);
    repeat (3) @(negedge clk);
    check_eq("tx_count", tx_q.size() - tx0, RSP_LEN);
    if (tx_q.size() - tx0 == RSP_LEN)
      for (int i = 0; i < RSP_LEN; i++) check_eq($sformatf("rsp_byte%0d", i), tx_q[tx0 + i], rsp[i]);
    check_eq("pkt_ok_count", n_ok - ok0, (st == STATUS_OK) ? 1 : 0);
    check_eq("pkt_err_count", n_err - err0, (st == STATUS_OK) ? 0 : 1);
    check_eq("reg_wr_count", wr_q.size() - wr0, wr ? 1 : 0);
    if (wr && wr_q.size() > wr0) check_eq("reg_wr_addr_data", wr_q[wr0], {addr[AW-1:0], data});
    if (wr) model_regs[addr[AW-1:0]] = data;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tx0, err0, to0, wr0, k;
    logic [7:0] c, a, d, x;
    reset = 1'b1; rx_complete = 1'b0; rx_data = 8'h00; rx_err = 2'b00;
    busy_hold = 0; load_regs = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      init_vals[i]  = 8'($urandom);
      model_regs[i] = init_vals[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {tx_data, tx_wr_en, reg_wr_en, reg_addr, reg_wdata, pkt_ok, pkt_err, timeout, busy}, 32'd0);
    load_regs = 1'b0;
    reset = 1'b0;

    do_frame(8'h01, 8'h03, 8'h7E, 8'h7C, 2, -1, 0);
    do_frame(8'h02, 8'h03, 8'h00, 8'h01, 2, -1, 0);
    do_frame(8'h01, 8'h03, 8'h7E, 8'h00, 0, -1, 0);
    do_frame(8'h09, 8'h00, 8'h00, 8'h09, 0, -1, 0);
    do_frame(8'h02, 8'h10, 8'h00, 8'h12, 0, -1, 0);
    do_frame(8'h01, 8'h0F, 8'hC3, 8'h01 ^ 8'h0F ^ 8'hC3, 0, TO - 1, 0);

    // Partial frame then silence.
    tx0 = tx_q.size(); to0 = n_to;
    align();
    send_byte(SOF_REQ, 2'b00);
    gap(1);
    send_byte(8'h01, 2'b00);
    k = 0;
    for (int i = 1; i <= TO + 10; i++) begin
      @(negedge clk);
      if (timeout) begin k = i; break; end
    end
    check_eq("timeout_latency", k, TO + 1);
    repeat (3) @(negedge clk);
    check_eq("timeout_count", n_to - to0, 1);
    check_eq("timeout_no_tx", tx_q.size() - tx0, 0);
    check_eq("timeout_idle", {31'b0, busy}, 32'd0);
    do_frame(8'h03, 8'h00, 8'h55, 8'h56, 1, -1, 0);

    // Receive error mid-frame, then idle noise.
    tx0 = tx_q.size(); err0 = n_err; wr0 = wr_q.size();
    align();
    send_byte(SOF_REQ, 2'b00);
    send_byte(8'h01, 2'b00);
    send_byte(8'h03, 2'b01);
    repeat (3) @(negedge clk);
    check_eq("rxerr_pkt_err", n_err - err0, 1);
    check_eq("rxerr_no_tx", tx_q.size() - tx0, 0);
    check_eq("rxerr_no_wr", wr_q.size() - wr0, 0);
    check_eq("rxerr_idle", {31'b0, busy}, 32'd0);
    align();
    send_byte(8'h00, 2'b00);
    send_byte(8'hFF, 2'b00);
    @(negedge clk);
    check_eq("noise_idle", {31'b0, busy}, 32'd0);
    do_frame(8'h02, 8'h03, 8'h00, 8'h01, 0, -1, 0);

    do_frame(8'h01, 8'h07, 8'h3C, 8'h01 ^ 8'h07 ^ 8'h3C, 20, -1, 1);
    do_frame(8'h02, 8'h07, 8'h00, 8'h02 ^ 8'h07, 20, -1, 1);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      c = (k < 3) ? CMD_WRITE : (k < 6) ? CMD_READ : (k < 8) ? CMD_ECHO : 8'($urandom);
      a = ($urandom_range(0, 4) != 0) ? 8'($urandom_range(0, NUM_REGS - 1)) : 8'($urandom);
      d = 8'($urandom);
      x = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_frame(c, a, d, c ^ a ^ d ^ x, $urandom_range(0, 4), -1, 0);
    end

    // Reset while the response is half sent.
    tx0 = tx_q.size(); wr0 = wr_q.size();
    busy_hold = 20;
    align();
    send_byte(SOF_REQ, 2'b00);
    send_byte(8'h02, 2'b00);
    send_byte(8'h05, 2'b00);
    send_byte(8'h00, 2'b00);
    send_byte(8'h07, 2'b00);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_q.size() >= tx0 + 2) break;
    end
    check_eq("reset_2nd_byte_seen", tx_q.size() - tx0, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_mid_rsp_outputs", {tx_data, tx_wr_en, reg_wr_en, reg_addr, reg_wdata, pkt_ok, pkt_err, timeout, busy}, 32'd0);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("reset_no_more_tx", tx_q.size() - tx0, 2);
    check_eq("reset_no_wr", wr_q.size() - wr0, 0);
    do_frame(8'h03, 8'h00, 8'hA5, 8'hA6, 3, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
